seg7_multi_display: RTL and testbench

SEG7_MULTI_DISPLAY -- requirements
Module: seg7_multi_display

---
 rtl/seg7_multi_display.sv | 164 ++++++++++++++++
 tb/tb_seg7_multi_display.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// ---------------------------------------------------------------------------
// seg7_multi_display
//   A value register of NUM_DIGITS nibbles drives NUM_DIGITS active-low
//   7-segment digits. The value is either static (loaded with Set_Flag) or
//   incremented once every TICK_DIV cycles. Arithmetic is hex or BCD.
//
// Parameters
//   NUM_DIGITS  number of digits (1..8)
//   TICK_DIV    CLOCK_50 cycles per count tick (>= 2)
//
// Ports
//   CLOCK_50    sole clock, rising edge
//   Reset_7Seg  synchronous active-high reset
//   Disp_Word   load value, nibble i feeds digit i
//   Set_Flag    load strobe; wins over a tick in the same cycle
//   Mode_Count  0 = static display, 1 = auto-increment
//   Mode_Bcd    0 = hex arithmetic/decode, 1 = BCD (A..F shown as dash)
//   Count_En    prescaler enable (only effective with Mode_Count = 1)
//   Seg_Bytes   registered gfedcba per digit, digit 0 at [6:0]
//   Load_Ack    one-cycle pulse following each load
//   Wrap_Pulse  one-cycle pulse following a rollover to all zero
//
// Build option
//   SEG7_LZ_BLANK_EN  when defined, zero digits above the most significant
//                     non-zero digit are blanked (digit 0 is never blanked)
// ---------------------------------------------------------------------------
module seg7_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 12500000
) (
    input  logic                    CLOCK_50,
    input  logic                    Reset_7Seg,
    input  logic [4*NUM_DIGITS-1:0] Disp_Word,
    input  logic                    Set_Flag,
    input  logic                    Mode_Count,
    input  logic                    Mode_Bcd,
    input  logic                    Count_En,
    output logic [7*NUM_DIGITS-1:0] Seg_Bytes,
    output logic                    Load_Ack,
    output logic                    Wrap_Pulse
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [VW-1:0] value_p0;
    logic [PW-1:0] presc_p0;
    logic          tick;
    logic          all_max;
    logic [VW-1:0] value_inc;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic bcd);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        // Non-decimal nibbles have no meaning in BCD mode
        if (bcd && (nib > 4'd9)) s = 7'b0111111;
        return s;
    endfunction

    // Decimal ripple increment; any digit >= 9 that receives the carry
    // becomes 0, which also normalises out-of-range nibbles.
    function automatic logic [VW-1:0] bcd_increment(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          carry;
        logic [3:0]    d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] decode_all(input logic [VW-1:0] v, input logic bcd);
        logic [SW-1:0] r;
        logic          upper_zero;
        logic [3:0]    nib;
        r          = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib        = v[4*i +: 4];
            upper_zero = upper_zero && (nib == 4'd0);
`ifdef SEG7_LZ_BLANK_EN
            if (upper_zero && (i != 0))
                r[7*i +: 7] = 7'b1111111;
            else
                r[7*i +: 7] = seg_decode(nib, bcd);
`else
            r[7*i +: 7] = seg_decode(nib, bcd);
`endif
        end
        return r;
    endfunction

    assign tick = Mode_Count && Count_En && (presc_p0 == PRE_MAX);

    // Rollover happens exactly when every digit is at its maximum for the
    // arithmetic selected in the tick cycle.
    always_comb begin
        all_max = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (Mode_Bcd)
                all_max = all_max && (value_p0[4*i +: 4] >= 4'd9);
            else
                all_max = all_max && (value_p0[4*i +: 4] == 4'hF);
        end
    end

    assign value_inc = Mode_Bcd ? bcd_increment(value_p0) : (value_p0 + VW'(1));

    // Stage p0: value register and prescaler; stage p1: decoded segments
    always_ff @(posedge CLOCK_50) begin
        if (Reset_7Seg) begin
            value_p0   <= '0;
            presc_p0   <= '0;
            Load_Ack   <= 1'b0;
            Wrap_Pulse <= 1'b0;
            Seg_Bytes  <= decode_all('0, Mode_Bcd);
        end else begin
            Load_Ack   <= Set_Flag;
            Wrap_Pulse <= tick && !Set_Flag && all_max;
            Seg_Bytes  <= decode_all(value_p0, Mode_Bcd);
            if (Set_Flag) begin
                value_p0 <= Disp_Word;
                presc_p0 <= '0;
            end else if (Mode_Count && Count_En) begin
                if (tick) begin
                    presc_p0 <= '0;
                    value_p0 <= value_inc;
                end else begin
                    presc_p0 <= presc_p0 + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_multi_display
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a behavioural model of the display (value, prescaler, pulses).
// ---------------------------------------------------------------------------
module tb_seg7_multi_display;

    localparam int ND = 6;
    localparam int TD = 4;

    localparam logic [6:0] LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk;
    logic        rst;
    logic [23:0] dw;
    logic        set;
    logic        mc;
    logic        bcd;
    logic        en;
    logic [41:0] Seg_Bytes;
    logic        Load_Ack;
    logic        Wrap_Pulse;

    logic [23:0] m_val;
    int          m_pre;
    logic        m_ack;
    logic        m_wrap;
    logic [41:0] m_seg;
    int          n_cmp;
    int          n_bad;
    logic [41:0] exp_rst;

    seg7_multi_display #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .CLOCK_50   (clk),
        .Reset_7Seg (rst),
        .Disp_Word  (dw),
        .Set_Flag   (set),
        .Mode_Count (mc),
        .Mode_Bcd   (bcd),
        .Count_En   (en),
        .Seg_Bytes  (Seg_Bytes),
        .Load_Ack   (Load_Ack),
        .Wrap_Pulse (Wrap_Pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d, input logic b);
        if (b && d > 9) return 7'b0111111;
        return LUT[d];
    endfunction

    // Display image of a value: digit i is blank when everything from digit i
    // upward is zero (only in the blanking build).
    function automatic logic [41:0] ref_disp(input logic [23:0] v, input logic b);
        logic [41:0] r;
        int          d;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            d = int'((v >> (4 * i)) & 24'hF);
            r[7*i +: 7] = ref_seg(d, b);
`ifdef SEG7_LZ_BLANK_EN
            if (i > 0 && (v >> (4 * i)) == 24'd0) r[7*i +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    // Next value after a tick plus whether it rolled over. BCD: the lowest
    // digit below 9 is bumped, every digit beneath it cleared.
    task automatic ref_next(input logic [23:0] v, input logic b,
                            output logic [23:0] nv, output logic wr);
        int k;
        if (!b) begin
            nv = v + 24'd1;
            wr = (v == 24'hFFFFFF);
        end else begin
            k = -1;
            for (int i = ND - 1; i >= 0; i--)
                if (v[4*i +: 4] < 4'd9) k = i;
            nv = v;
            if (k < 0) begin
                nv = '0;
                wr = 1'b1;
            end else begin
                for (int i = 0; i < k; i++) nv[4*i +: 4] = 4'd0;
                nv[4*k +: 4] = v[4*k +: 4] + 4'd1;
                wr = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare all outputs 1 time unit later.
    task automatic cyc();
        logic [23:0] old;
        logic [23:0] nv;
        logic        wr;
        logic        tk;
        @(posedge clk);
        old = m_val;
        if (rst) begin
            m_val  = '0;
            m_pre  = 0;
            m_ack  = 1'b0;
            m_wrap = 1'b0;
            m_seg  = ref_disp(24'd0, bcd);
        end else begin
            m_seg  = ref_disp(old, bcd);
            m_ack  = set;
            m_wrap = 1'b0;
            tk     = mc && en && (m_pre == TD - 1);
            if (set) begin
                m_val = dw;
                m_pre = 0;
            end else if (mc && en) begin
                if (tk) begin
                    m_pre = 0;
                    ref_next(old, bcd, nv, wr);
                    m_val  = nv;
                    m_wrap = wr;
                end else begin
                    m_pre++;
                end
            end
        end
        #1;
        check("seg", Seg_Bytes, m_seg);
        check("ack", {41'b0, Load_Ack}, {41'b0, m_ack});
        check("wrap", {41'b0, Wrap_Pulse}, {41'b0, m_wrap});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_val = '0; m_pre = 0; m_ack = 0; m_wrap = 0; m_seg = '0;
        rst = 1; set = 0; mc = 0; bcd = 0; en = 0; dw = '0;
        #2;

        // Reset then release
        cyc(); cyc();
        rst = 0;
        cyc();
`ifdef SEG7_LZ_BLANK_EN
        exp_rst = {{5{7'b1111111}}, 7'b1000000};
`else
        exp_rst = {6{7'b1000000}};
`endif
        check("rst_seg", Seg_Bytes, exp_rst);

        // Static hex load
        dw = 24'h00A5F3; set = 1;
        cyc();
        check("load_ack", {41'b0, Load_Ack}, 42'd1);
        set = 0;
        cyc();
        check("a5f3_d012", {21'b0, Seg_Bytes[20:0]}, {21'b0, 7'b0010010, 7'b0001110, 7'b0110000});

        // Hex count through rollover
        mc = 1; en = 1; bcd = 0; dw = 24'hFFFFFE; set = 1;
        cyc();
        set = 0;
        repeat (5) cyc();
        check("hex_ffffff", Seg_Bytes, {6{7'b0001110}});
        repeat (3) cyc();
        check("wrap_hi", {41'b0, Wrap_Pulse}, 42'd1);
        cyc();
        check("wrap_lo", {41'b0, Wrap_Pulse}, 42'd0);
        check("zero_d0", {35'b0, Seg_Bytes[6:0]}, {35'b0, 7'b1000000});

        // BCD carry and dash
        bcd = 1; dw = 24'h000099; set = 1;
        cyc();
        set = 0;
        repeat (5) cyc();
        check("bcd_100", {21'b0, Seg_Bytes[20:0]}, {21'b0, 7'b1111001, 7'b1000000, 7'b1000000});
        dw = 24'h0000C0; set = 1;
        cyc();
        set = 0;
        cyc();
        check("bcd_dash", {35'b0, Seg_Bytes[13:7]}, {35'b0, 7'b0111111});

        // Load in the tick cycle wins and clears the prescaler
        bcd = 0; dw = 24'h000000; set = 1;
        cyc();
        set = 0;
        repeat (3) cyc();
        dw = 24'h000010; set = 1;
        cyc();
        set = 0; en = 0;
        repeat (10) cyc();
        check("hold_10", {28'b0, Seg_Bytes[13:0]}, {28'b0, 7'b1111001, 7'b1000000});
        en = 1;
        repeat (4) cyc();
        check("pre_clr", {35'b0, Seg_Bytes[6:0]}, {35'b0, 7'b1000000});
        cyc();
        check("first_inc", {35'b0, Seg_Bytes[6:0]}, {35'b0, 7'b1111001});

        // Mode switch does not touch the value, only its decode
        mc = 0; dw = 24'h0000AB; set = 1;
        cyc();
        set = 0;
        repeat (3) cyc();
        bcd = 1;
        repeat (2) cyc();
        bcd = 0;
        repeat (2) cyc();

        // Randomized traffic
        repeat (600) begin
            rst = ($urandom_range(0, 59) == 0);
            set = ($urandom_range(0, 9) == 0);
            mc  = ($urandom_range(0, 7) != 0);
            en  = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 39) == 0) bcd = ~bcd;
            case ($urandom_range(0, 3))
                0: dw = 24'($urandom);
                1: dw = {20'hFFFFF, 4'($urandom_range(12, 15))};
                2: dw = {20'h99999, 4'($urandom_range(7, 15))};
                default: begin
                    for (int i = 0; i < ND; i++) dw[4*i +: 4] = 4'($urandom_range(0, 9));
                end
            endcase
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
